// File: rtl/vga_pkg.sv
// Shared constants and types for the TinyVGA dither/output stage.
// Holds the 4x4 Bayer threshold table, the PMOD pin order and the pipeline word layout.
package vga_pkg;

    // Indexed as BAYER4x4[row][column] = BAYER4x4[vpos_lsb][hpos_lsb].
    localparam logic [0:3][0:3][3:0] BAYER4x4 = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    localparam int UO_HSYNC = 7;
    localparam int UO_B0    = 6;
    localparam int UO_G0    = 5;
    localparam int UO_R0    = 4;
    localparam int UO_VSYNC = 3;
    localparam int UO_B1    = 2;
    localparam int UO_G1    = 1;
    localparam int UO_R1    = 0;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb2_t;

    typedef struct packed {
        rgb2_t rgb;
        logic  hs;
        logic  vs;
        logic  de;
    } pix_t;

endpackage

// File: rtl/vga_bayer_quant.sv
// Combinational ordered-dither quantiser: one IN_W-bit channel down to 2 bits
// against a 4-bit Bayer threshold.
module vga_bayer_quant
    import vga_pkg::*;
#(
    parameter int IN_W = 4
) (
    input  logic [IN_W-1:0] c,
    input  logic [3:0]      t,
    output logic [1:0]      q2
);

    logic [1:0] q;
    logic [3:0] rem4;

    assign q = c[IN_W-1 -: 2];

    // The remainder is the fraction below the kept bits, left-aligned to 4 bits.
    if (IN_W >= 6) begin : g_trunc
        assign rem4 = c[IN_W-3 -: 4];
    end else begin : g_pad
        assign rem4 = {c[IN_W-3:0], {(6-IN_W){1'b0}}};
    end

    assign q2 = (rem4 > t && q != 2'b11) ? q + 2'd1 : q;

endmodule

// File: rtl/vga_dither_out.sv
// Final video stage: Bayer dither to 2 bpp, blanking, sync alignment and PMOD packing.
// Define VGA_DITHER_TEMPORAL_EN to invert the dither pattern on alternate frames.
module vga_dither_out
    import vga_pkg::*;
#(
    parameter int IN_W        = 4,
    parameter int PIPE_STAGES = 2,
    parameter bit SYNC_INVERT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] r_in,
    input  logic [IN_W-1:0] g_in,
    input  logic [IN_W-1:0] b_in,
    input  logic [1:0]      hpos_lsb,
    input  logic [1:0]      vpos_lsb,
    input  logic            display_on,
    input  logic            hsync,
    input  logic            vsync,
    output logic [7:0]      uo_out,
    output logic [5:0]      rgb_out,
    output logic            de_out
);

    localparam pix_t SYNC_MASK = '{rgb: '0, hs: SYNC_INVERT, vs: SYNC_INVERT, de: 1'b0};

    logic [3:0] t_base;
    logic [3:0] t_eff;
    logic [1:0] r_q2, g_q2, b_q2;
    pix_t       s1_d;

    assign t_base = BAYER4x4[vpos_lsb][hpos_lsb];

`ifdef VGA_DITHER_TEMPORAL_EN
    logic frame_parity;
    logic vsync_q;

    // vsync_q resets high so a vsync held across reset release is not seen as a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_parity <= 1'b0;
            vsync_q      <= 1'b1;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q)
                frame_parity <= ~frame_parity;
        end
    end

    assign t_eff = t_base ^ {4{frame_parity}};
`else
    assign t_eff = t_base;
`endif

    vga_bayer_quant #(.IN_W(IN_W)) u_quant_r (.c(r_in), .t(t_eff), .q2(r_q2));
    vga_bayer_quant #(.IN_W(IN_W)) u_quant_g (.c(g_in), .t(t_eff), .q2(g_q2));
    vga_bayer_quant #(.IN_W(IN_W)) u_quant_b (.c(b_in), .t(t_eff), .q2(b_q2));

    always_comb begin
        s1_d     = '0;
        s1_d.hs  = hsync;
        s1_d.vs  = vsync;
        s1_d.de  = display_on;
        if (display_on)
            s1_d.rgb = '{r: r_q2, g: g_q2, b: b_q2};
    end

    pix_t stage_d [PIPE_STAGES];
    pix_t stage_q [PIPE_STAGES];

    assign stage_d[0] = s1_d;
    for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_delay
        assign stage_d[k] = stage_q[k-1];
    end

    // The last stage is the output register, where the sync polarity is applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < PIPE_STAGES; k++)
                stage_q[k] <= (k == PIPE_STAGES - 1) ? SYNC_MASK : '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++)
                stage_q[k] <= (k == PIPE_STAGES - 1) ? (stage_d[k] ^ SYNC_MASK) : stage_d[k];
        end
    end

    pix_t out_pix;
    assign out_pix = stage_q[PIPE_STAGES-1];

    always_comb begin
        uo_out           = '0;
        uo_out[UO_HSYNC] = out_pix.hs;
        uo_out[UO_B0]    = out_pix.rgb.b[0];
        uo_out[UO_G0]    = out_pix.rgb.g[0];
        uo_out[UO_R0]    = out_pix.rgb.r[0];
        uo_out[UO_VSYNC] = out_pix.vs;
        uo_out[UO_B1]    = out_pix.rgb.b[1];
        uo_out[UO_G1]    = out_pix.rgb.g[1];
        uo_out[UO_R1]    = out_pix.rgb.r[1];
    end

    assign rgb_out = out_pix.rgb;
    assign de_out  = out_pix.de;

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench for vga_dither_out (IN_W=4, PIPE_STAGES=2), with a second SYNC_INVERT=1 instance.
// Honours VGA_DITHER_TEMPORAL_EN in its reference model.
module tb_vga_dither_out;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] r_in, g_in, b_in;
    logic [1:0] hpos_lsb, vpos_lsb;
    logic       display_on, hsync, vsync;
    logic [7:0] uo_out, uo_out_inv;
    logic [5:0] rgb_out, rgb_out_inv;
    logic       de_out, de_out_inv;

    always #20 clk = ~clk;

    vga_dither_out #(.IN_W(4), .PIPE_STAGES(P), .SYNC_INVERT(1'b0)) dut (
        .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hpos_lsb(hpos_lsb), .vpos_lsb(vpos_lsb), .display_on(display_on),
        .hsync(hsync), .vsync(vsync), .uo_out(uo_out), .rgb_out(rgb_out), .de_out(de_out)
    );

    vga_dither_out #(.IN_W(4), .PIPE_STAGES(P), .SYNC_INVERT(1'b1)) dut_inv (
        .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hpos_lsb(hpos_lsb), .vpos_lsb(vpos_lsb), .display_on(display_on),
        .hsync(hsync), .vsync(vsync), .uo_out(uo_out_inv), .rgb_out(rgb_out_inv), .de_out(de_out_inv)
    );

    typedef struct packed {
        logic [7:0] uo;
        logic [5:0] rgb;
        logic       de;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bayer[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    bit   m_par;
    bit   m_vsq;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [1:0] quant(input int c, input int t);
        int q   = c / 4;
        int rem = (c % 4) * 4;
        if (rem > t && q < 3)
            q = q + 1;
        return q[1:0];
    endfunction

    function automatic exp_t modelPixel(input int r, input int g, input int b, input int h,
                                        input int v, input bit de, input bit hs, input bit vs);
        exp_t       e;
        logic [1:0] rr, gg, bb;
        int         t = bayer[v*4 + h];
`ifdef VGA_DITHER_TEMPORAL_EN
        if (m_par)
            t = 15 - t;
        if (vs && !m_vsq)
            m_par = ~m_par;
        m_vsq = vs;
`endif
        rr = de ? quant(r, t) : 2'b00;
        gg = de ? quant(g, t) : 2'b00;
        bb = de ? quant(b, t) : 2'b00;
        e.uo  = {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
        e.rgb = {rr, gg, bb};
        e.de  = de;
        return e;
    endfunction

    task automatic compareAll(input exp_t e);
        checkOutput("uo_out", uo_out, e.uo);
        checkOutput("rgb_out", {2'b00, rgb_out}, {2'b00, e.rgb});
        checkOutput("de_out", {7'b0, de_out}, {7'b0, e.de});
        checkOutput("uo_out_inv", uo_out_inv, e.uo ^ 8'h88);
    endtask

    task automatic applyStimulus(input int r, input int g, input int b, input int h,
                                 input int v, input bit de, input bit hs, input bit vs);
        @(posedge clk);
        #1;
        if (exp_q.size() >= P)
            compareAll(exp_q.pop_front());
        r_in       = 4'(r);
        g_in       = 4'(g);
        b_in       = 4'(b);
        hpos_lsb   = 2'(h);
        vpos_lsb   = 2'(v);
        display_on = de;
        hsync      = hs;
        vsync      = vs;
        exp_q.push_back(modelPixel(r, g, b, h, v, de, hs, vs));
    endtask

    // Reset with full-white visible input held; outputs must stay at reset values throughout.
    task automatic applyReset(input int n);
        exp_t rst_e;
        reset      = 1'b1;
        r_in       = 4'hF;
        g_in       = 4'hF;
        b_in       = 4'hF;
        hpos_lsb   = 2'd0;
        vpos_lsb   = 2'd0;
        display_on = 1'b1;
        hsync      = 1'b0;
        vsync      = 1'b0;
        exp_q.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput("rst_uo_out", uo_out, 8'h00);
            checkOutput("rst_uo_out_inv", uo_out_inv, 8'h88);
            checkOutput("rst_rgb_out", {2'b00, rgb_out}, 8'h00);
            checkOutput("rst_de_out", {7'b0, de_out}, 8'h00);
        end
        reset = 1'b0;
        m_par = 1'b0;
        m_vsq = 1'b1;
        rst_e = '0;
        repeat (P - 1) exp_q.push_back(rst_e);
        exp_q.push_back(modelPixel(15, 15, 15, 0, 0, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        applyReset(3);

        // Blanking: sync passes, colour forced off.
        applyStimulus(15, 15, 15, 0, 0, 1'b0, 1'b1, 1'b0);

        // Threshold walk with rem4 = 8.
        applyStimulus(6, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(6, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(6, 0, 0, 3, 1, 1'b1, 1'b0, 1'b0);

        // Saturation at q=3 and no round-up for rem4 = 0.
        applyStimulus(15, 15, 15, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4, 4, 4, 0, 0, 1'b1, 1'b0, 1'b0);

        // Two frames: vsync pulse then a rem4=8 pixel at (1,0), twice.
        for (int f = 0; f < 2; f++) begin
            applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
            applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            applyStimulus(6, 6, 6, 1, 0, 1'b1, 1'b0, 1'b0);
        end

        // Single-cycle hsync aligned with a saturating pixel.
        applyStimulus(0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(12, 12, 12, 2, 2, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++)
            applyStimulus($urandom_range(15), $urandom_range(15), $urandom_range(15),
                          $urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
                          1'($urandom_range(1)), ($urandom_range(7) == 0));

        // Mid-frame reset must flush the pipeline.
        applyReset(2);
        for (int i = 0; i < 60; i++)
            applyStimulus($urandom_range(15), $urandom_range(15), $urandom_range(15),
                          $urandom_range(3), $urandom_range(3), 1'($urandom_range(1)),
                          1'($urandom_range(1)), ($urandom_range(5) == 0));

        repeat (P) applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
